hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised register scoreboard for the decode stage of the pipelined MIPS core. It replaces fixed EX/MEM address-compare forwarding and the single load-use stall with per-register pending-latency counters and age counters. This lets producers with any result latency (ALU, load, multi-cycle MUL) share one hazard mechanism. It sits beside decode and drives the stall, issue and per-operand forward-select signals.

## Interface
- `NREG`, 32: architectural registers tracked; register 0 is never tracked.
- `AW`, 5: register address width.
- `CW`, 3: latency counter width; maximum latency is 2^CW-1.
- `FWD_DEPTH`, 2: number of forwarding stages after issue (1=EX, 2=MEM); must be ≤3.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `id_valid` in 1: decode holds an instruction.
- `id_kill` in 1: squash the decode instruction this cycle (branch/jump redirect).
- `id_rs_addr`, `id_rt_addr` in AW: source registers.
- `id_rs_used`, `id_rt_used` in 1: source is actually read.
- `id_rd_addr` in AW: destination register.
- `id_rd_we` in 1: instruction writes `id_rd_addr`.
- `id_lat` in CW: cycles after issue before a dependent may issue (ALU 0, load 1, MUL 3).
- `stall` out 1: hold PC and IF/ID; insert a bubble into EX.
- `issue` out 1: instruction leaves decode this cycle.
- `fwd_rs_sel`, `fwd_rt_sel` out 2: 0 = register file, 1 = EX result, 2 = MEM write data, 3 = reserved.
- `busy` out 1: any pending counter is nonzero.

## Operation
- State per register r (1..NREG-1):
  - `cnt[r]` (CW bits), the remaining latency.
  - `age[r]` (2 bits), cycles since the last issue writing r, saturating at FWD_DEPTH+1.
- Hazard, combinational:
  - raw = (id_rs_used & rs≠0 & cnt[rs]≠0) | (id_rt_used & rt≠0 & cnt[rt]≠0).
  - waw = id_rd_we & rd≠0 & cnt[rd] > id_lat.
- stall = id_valid & ~id_kill & (raw | waw).
- issue = id_valid & ~id_kill & ~(raw | waw).
- fwd_x_sel = age[x] when x≠0 and age[x] ≤ FWD_DEPTH, else 0. It is valid whenever issue=1 and is don't-care otherwise.
- Each cycle, every nonzero cnt decrements by 1 and every age below FWD_DEPTH+1 increments by 1.
- On issue with id_rd_we & rd≠0: cnt[rd] ← id_lat and age[rd] ← 1. This overrides the decrement/increment for that register in the same cycle.
- Writes to register 0 are ignored; reads of register 0 never stall and always select 0.
- A killed instruction changes no state; in-flight producers keep counting.
- The caller guarantees that a producer with id_lat ≥ FWD_DEPTH has its result in the register file once its cnt reaches 0.
- busy = OR of all cnt≠0.

## Timing
- stall, issue and fwd_sel are combinational from current state and ID inputs. State updates on the rising edge of `clk`.
- Reset (rst=0 at a clock edge):
  - all cnt = 0 and all age = FWD_DEPTH+1;
  - outputs therefore become stall=0, busy=0, fwd_sel=0, and issue=id_valid&~id_kill.
- A reset mid-stall clears all pending state the same edge.
- ALU producer issued at cycle T (lat 0):
  - a dependent issues at T+1 with sel=1;
  - at T+2 with sel=2;
  - from T+3 with sel=0.
- Load issued at T (lat 1):
  - a dependent stalls at T+1 (cnt=1);
  - it issues at T+2 with sel=2.
- MUL issued at T (lat 3):
  - a dependent stalls T+1 through T+3;
  - it issues at T+4 with sel=0.
- Back-to-back issue to the same rd reloads cnt and age; the younger producer wins forwarding.
- Counters saturate at 0; no wrap.
- id_lat=0 for a WAW case never stalls when cnt[rd]=0.

## Test plan
- Reset: hold rst=0 for 2 cycles with id_valid=1 and rs=5 used → stall=0, busy=0, fwd_rs_sel=0, issue=1.
- ALU chain: issue add $3 (lat 0), then add $4,$3,$3 next cycle → no stall, fwd_rs_sel=fwd_rt_sel=1; a third instruction reading $3 one cycle later gets sel=2.
- Load-use: lb $2 (lat 1), then addu $5,$2,$0 → exactly 1 stall cycle, then issue with fwd_rs_sel=2.
- MUL latency and WAW:
  - mul $7 (lat 3), then a reader of $7 → 3 stall cycles, issue on the 4th with sel=0;
  - separately, mul $7 then addiu $7 (lat 0) → stall until cnt[$7]=0.
- Register 0 and kill:
  - lb $0 followed by a reader of $0 → no stall;
  - id_kill=1 on a write to $9 → issue=0, and cnt[$9] stays 0 next cycle.
- Reset mid-stall: lb $2 (lat 1), reader of $2 stalling, rst=0 for one edge → next cycle busy=0 and the reader issues with sel=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard scoreboard signal bundle.
// The master is the decode stage and the slave is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 3
);
    logic          id_valid;
    logic          id_kill;
    logic [AW-1:0] id_rs_addr;
    logic [AW-1:0] id_rt_addr;
    logic          id_rs_used;
    logic          id_rt_used;
    logic [AW-1:0] id_rd_addr;
    logic          id_rd_we;
    logic [CW-1:0] id_lat;
    logic          stall;
    logic          issue;
    logic [1:0]    fwd_rs_sel;
    logic [1:0]    fwd_rt_sel;
    logic          busy;

    modport master (
        output id_valid, id_kill, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_rd_addr, id_rd_we, id_lat,
        input  stall, issue, fwd_rs_sel, fwd_rt_sel, busy
    );

    modport slave (
        input  id_valid, id_kill, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_rd_addr, id_rd_we, id_lat,
        output stall, issue, fwd_rs_sel, fwd_rt_sel, busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-latency and age scoreboard for decode.
// It produces stall, issue and the operand forward selects.
module hazard_scoreboard #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned CW        = 3,
    parameter int unsigned FWD_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  sb
);
    // An age register one bit wider is needed only when the saturation value (FWD_DEPTH+1) reaches 4.
    localparam int unsigned AGE_W = (FWD_DEPTH >= 3) ? 3 : 2;
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(FWD_DEPTH + 1);
    localparam logic [AGE_W-1:0] AGE_MAX_FWD = AGE_W'(FWD_DEPTH);

    logic [CW-1:0]    cnt_q [NREG];
    logic [AGE_W-1:0] age_q [NREG];

    logic raw, waw, hazard, live, wr_en;
    logic rs_nz, rt_nz, rd_nz;
    logic [AGE_W-1:0] rs_age, rt_age;

    always_comb begin
        rs_nz  = (sb.id_rs_addr != '0);
        rt_nz  = (sb.id_rt_addr != '0);
        rd_nz  = (sb.id_rd_addr != '0);
        raw    = (sb.id_rs_used && rs_nz && (cnt_q[sb.id_rs_addr] != '0)) ||
                 (sb.id_rt_used && rt_nz && (cnt_q[sb.id_rt_addr] != '0));
        waw    = sb.id_rd_we && rd_nz && (cnt_q[sb.id_rd_addr] > sb.id_lat);
        hazard = raw || waw;
        live   = sb.id_valid && !sb.id_kill;
        wr_en  = live && !hazard && sb.id_rd_we && rd_nz;

        sb.stall = live && hazard;
        sb.issue = live && !hazard;

        rs_age = age_q[sb.id_rs_addr];
        rt_age = age_q[sb.id_rt_addr];
        sb.fwd_rs_sel = (rs_nz && (rs_age <= AGE_MAX_FWD)) ? rs_age[1:0] : 2'd0;
        sb.fwd_rt_sel = (rt_nz && (rt_age <= AGE_MAX_FWD)) ? rt_age[1:0] : 2'd0;
    end

    always_comb begin
        sb.busy = 1'b0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (cnt_q[r] != '0) begin
                sb.busy = 1'b1;
            end
        end
    end

    // Register 0 is never loaded (wr_en requires rd != 0), so it stays idle.
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < NREG; r++) begin
            if (!rst) begin
                cnt_q[r] <= '0;
                age_q[r] <= AGE_SAT;
            end else if (wr_en && (sb.id_rd_addr == AW'(r))) begin
                cnt_q[r] <= sb.id_lat;
                age_q[r] <= AGE_W'(1);
            end else begin
                if (cnt_q[r] != '0) begin
                    cnt_q[r] <= cnt_q[r] - CW'(1);
                end
                if (age_q[r] < AGE_SAT) begin
                    age_q[r] <= age_q[r] + AGE_W'(1);
                end
            end
        end
    end
endmodule
